// File: rtl/digi_chan_sequencer_pkg.sv
// rtl/digi_chan_sequencer_pkg.sv - shared state encodings, header tag and channel-count limit
package digi_chan_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HEADER = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  localparam logic [3:0] HDR_TAG  = 4'hA;
  localparam int         MAX_CHAN = 16;
  localparam int         SEL_W    = 4;

  function automatic bit chan_ok(input int n);
    return (n >= 1) && (n <= MAX_CHAN);
  endfunction

endpackage

// File: rtl/digi_chan_sequencer_prio_enc.sv
// rtl/digi_chan_sequencer_prio_enc.sv - index of the highest set request bit plus an any-set flag
module digi_chan_sequencer_prio_enc
  import digi_chan_sequencer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = SEL_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/digi_chan_sequencer.sv
// rtl/digi_chan_sequencer.sv - EOS-triggered multi-channel readout onto one valid/ready word stream
// Optional per-channel header word when DIGI_SEQ_HEADER_EN is defined.
module digi_chan_sequencer
  import digi_chan_sequencer_pkg::*;
#(
  parameter int CHAN    = 8,
  parameter int WIDTH   = 12,
  parameter int DOUT_W  = 16,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic                    CK50,
  input  logic                    RST,
  input  logic                    EOS,
  input  logic [CHAN-1:0]         chan_en,
  input  logic [CNT_W-1:0]        how_many,
  input  logic [CHAN*WIDTH-1:0]   ch_data,
  input  logic [CHAN-1:0]         ch_valid,
  input  logic [CHAN-1:0]         ch_done,
  output logic [CHAN-1:0]         ch_rd_req,
  output logic [DOUT_W-1:0]       dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic [15:0]             frame_cnt,
  output logic [CHAN-1:0]         err_mask,
  output logic                    eos_overrun
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam int PAD = DOUT_W - WIDTH;

  if (!chan_ok(CHAN)) begin : g_chan_range
    $error("CHAN must be in 1..16");
  end

  state_t            state, state_next;
  logic              eos_q;
  logic              eos_edge;
  logic [CHAN-1:0]   pending;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  top_idx;
  logic              top_any;
  logic [CNT_W-1:0]  cnt;
  logic [TMO_W-1:0]  tmo;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_valid;
  logic              sel_done;
  logic [CHAN-1:0]   sel_oh;
  logic              out_free;
  logic              chan_end;
  logic              rd_go;
  logic              xfer;
  logic              hdr_go;
  logic              drop;
  logic              tmo_hit;
  logic [DOUT_W-1:0] sample_word;
  logic [DOUT_W-1:0] hdr_word;

  digi_chan_sequencer_prio_enc #(.N(CHAN)) u_prio (
    .req (pending),
    .idx (top_idx),
    .any (top_any)
  );

  assign eos_edge = EOS & ~eos_q;
  assign busy     = (state != ST_IDLE);
  assign out_free = ~dout_valid | dout_ready;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_done  = 1'b0;
    sel_oh    = '0;
    for (int c = 0; c < CHAN; c++) begin
      if (sel == SEL_W'(c)) begin
        sel_data  = ch_data[c*WIDTH +: WIDTH];
        sel_valid = ch_valid[c];
        sel_done  = ch_done[c];
        sel_oh[c] = 1'b1;
      end
    end
  end

  // Channel is finished once its buffer is dry or the per-channel limit is met.
  assign chan_end    = (sel_done & ~sel_valid) | ((how_many != '0) && (cnt == how_many));
  assign ch_rd_req   = rd_go ? sel_oh : '0;
  assign sample_word = DOUT_W'(sel_data) << PAD;
  assign hdr_word    = {HDR_TAG, sel, frame_cnt[DOUT_W-9:0]};

  always_ff @(posedge CK50) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_go      = 1'b0;
    xfer       = 1'b0;
    hdr_go     = 1'b0;
    drop       = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (eos_edge && (chan_en != '0)) state_next = ST_SELECT;
      end
      ST_SELECT: begin
        if (top_any) begin
`ifdef DIGI_SEQ_HEADER_EN
          state_next = ST_HEADER;
`else
          state_next = ST_STREAM;
`endif
        end else if (out_free) begin
          state_next = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (out_free) begin
          hdr_go     = 1'b1;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (chan_end) begin
          drop       = 1'b1;
          state_next = ST_SELECT;
        end else if (out_free) begin
          rd_go = 1'b1;
          xfer  = sel_valid;
          if (!sel_valid && (tmo == TMO_LAST)) begin
            tmo_hit    = 1'b1;
            drop       = 1'b1;
            state_next = ST_SELECT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Edge detector starts primed high so a level already present at reset is not an edge.
  always_ff @(posedge CK50) begin
    if (RST) begin
      eos_q       <= 1'b1;
      pending     <= '0;
      sel         <= '0;
      cnt         <= '0;
      tmo         <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_cnt   <= '0;
      err_mask    <= '0;
      eos_overrun <= 1'b0;
    end else begin
      eos_q <= EOS;
      if (eos_edge) begin
        if (state == ST_IDLE) begin
          pending     <= chan_en;
          frame_cnt   <= frame_cnt + 16'd1;
          err_mask    <= '0;
          eos_overrun <= 1'b0;
        end else begin
          eos_overrun <= 1'b1;
        end
      end
      if (state == ST_SELECT) begin
        sel <= top_idx;
        cnt <= '0;
        tmo <= '0;
      end
      if (drop)    pending  <= pending & ~sel_oh;
      if (tmo_hit) err_mask <= err_mask | sel_oh;
      if (xfer) begin
        cnt <= cnt + 1'b1;
        tmo <= '0;
      end else if (rd_go) begin
        tmo <= tmo + 1'b1;
      end
      if (xfer) begin
        dout       <= sample_word;
        dout_valid <= 1'b1;
      end else if (hdr_go) begin
        dout       <= hdr_word;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digi_chan_sequencer.sv
// tb/tb_digi_chan_sequencer.sv - scoreboard bench for digi_chan_sequencer with FWFT channel models
module tb_digi_chan_sequencer;

  localparam int CHAN    = 8;
  localparam int WIDTH   = 12;
  localparam int DOUT_W  = 16;
  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 16;

  logic                  CK50 = 1'b0;
  logic                  RST = 1'b1;
  logic                  EOS = 1'b0;
  logic [CHAN-1:0]       chan_en = '0;
  logic [CNT_W-1:0]      how_many = '0;
  logic [CHAN*WIDTH-1:0] ch_data = '0;
  logic [CHAN-1:0]       ch_valid = '0;
  logic [CHAN-1:0]       ch_done = '0;
  logic [CHAN-1:0]       ch_rd_req;
  logic [DOUT_W-1:0]     dout;
  logic                  dout_valid;
  logic                  dout_ready = 1'b1;
  logic                  busy;
  logic [15:0]           frame_cnt;
  logic [CHAN-1:0]       err_mask;
  logic                  eos_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic [DOUT_W-1:0] exp_q[$];
  logic [15:0]       exp_frame = '0;

  logic [WIDTH-1:0] mem [CHAN][16];
  int               head [CHAN];
  int               tail [CHAN];
  bit               done_en [CHAN];
  int               pulses [CHAN];
  logic [CHAN-1:0]  rd_snap = '0;

  digi_chan_sequencer #(
    .CHAN(CHAN), .WIDTH(WIDTH), .DOUT_W(DOUT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CK50(CK50), .RST(RST), .EOS(EOS), .chan_en(chan_en), .how_many(how_many),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_done(ch_done), .ch_rd_req(ch_rd_req),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .frame_cnt(frame_cnt), .err_mask(err_mask), .eos_overrun(eos_overrun)
  );

  always #5 CK50 = ~CK50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop strobes are captured mid-cycle, then applied just after the edge they were sampled on.
  always @(negedge CK50) rd_snap <= ch_rd_req;

  always @(posedge CK50) begin
    #1;
    for (int c = 0; c < CHAN; c++) begin
      if (!RST && rd_snap[c]) begin
        pulses[c]++;
        if (head[c] < tail[c]) head[c]++;
      end
      ch_valid[c] = head[c] < tail[c];
      ch_done[c]  = done_en[c] && (head[c] >= tail[c]);
      ch_data[c*WIDTH +: WIDTH] = mem[c][head[c] & 15];
    end
  end

  always @(negedge CK50) begin
    if (!RST && dout_valid && dout_ready) begin
      n_acc++;
      if (exp_q.size() > 0) check("dout", dout, exp_q.pop_front());
      else                  check("sb_underflow", 32'(exp_q.size()), 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: still running, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CK50);
    #1;
  endtask

  task automatic load_chan(input int c, input int n, input bit d);
    for (int i = 0; i < n; i++) begin
      mem[c][tail[c] & 15] = WIDTH'($urandom_range(0, 4095));
      tail[c]++;
    end
    done_en[c] = d;
  endtask

  task automatic flush_chans();
    for (int c = 0; c < CHAN; c++) begin
      tail[c]    = head[c];
      done_en[c] = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [CHAN-1:0] mask);
    int k;
    chan_en = mask;
    exp_frame++;
    for (int c = CHAN - 1; c >= 0; c--) begin
      if (mask[c]) begin
`ifdef DIGI_SEQ_HEADER_EN
        exp_q.push_back({4'hA, 4'(c), exp_frame[DOUT_W-9:0]});
`endif
        k = tail[c] - head[c];
        if (how_many != '0 && k > int'(how_many)) k = int'(how_many);
        for (int i = 0; i < k; i++) exp_q.push_back({mem[c][(head[c] + i) & 15], 4'h0});
      end
    end
    EOS = 1'b1;
    tick();
    EOS = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int a0, n, p0;
    logic [DOUT_W-1:0] hd;

    repeat (3) tick();
    check("rst_dout", dout, 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_err", err_mask, 0);
    check("rst_overrun", 32'(eos_overrun), 0);
    check("rst_rd_req", ch_rd_req, 0);
    RST = 1'b0;
    repeat (2) tick();

    // Two channels, highest first
    load_chan(7, 3, 1'b1);
    load_chan(0, 2, 1'b1);
    tick();
    run_frame(8'h81);
    wait_idle("t1");
    check("t1_frame", frame_cnt, exp_frame);
    check("t1_err", err_mask, 0);

    // Single channel; header word precedes samples when enabled
    load_chan(2, 3, 1'b1);
    tick();
    run_frame(8'h04);
    wait_idle("t2");
    check("t2_valid_low", 32'(dout_valid), 0);

    // Sample limit stops the channel early
    how_many = 12'd4;
    load_chan(3, 10, 1'b1);
    tick();
    p0 = pulses[3];
    run_frame(8'h08);
    wait_idle("t3");
    check("t3_pops", 32'(pulses[3] - p0), 4);
    how_many = '0;
    flush_chans();
    tick();

    // Output back-pressure mid-stream
    load_chan(1, 6, 1'b1);
    tick();
    run_frame(8'h02);
    a0 = n_acc;
    n = 0;
    while (n_acc < a0 + 2 && n < 100) begin
      tick();
      n++;
    end
    check("t4_started", 32'(n_acc >= a0 + 2), 1);
    dout_ready = 1'b0;
    tick();
    tick();
    hd = dout;
    p0 = pulses[1];
    repeat (20) tick();
    check("t4_dout_held", dout, hd);
    check("t4_valid_held", 32'(dout_valid), 1);
    check("t4_no_pops", 32'(pulses[1]), 32'(p0));
    check("t4_no_timeout", err_mask, 0);
    dout_ready = 1'b1;
    wait_idle("t4");

    // Channel 5 never produces data and times out; channel 0 still read
    load_chan(0, 2, 1'b1);
    tick();
    run_frame(8'h21);
    repeat (10) tick();
    check("t5_err_early", err_mask, 0);
    wait_idle("t5");
    check("t5_err", err_mask, 8'h20);

    // EOS while busy, then reset mid-frame
    load_chan(6, 8, 1'b1);
    tick();
    run_frame(8'h40);
    tick();
    tick();
    EOS = 1'b1;
    tick();
    check("t6_overrun", 32'(eos_overrun), 1);
    check("t6_frame_kept", frame_cnt, exp_frame);
    check("t6_busy", 32'(busy), 1);
    EOS = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    check("t6_rst_dout", dout, 0);
    check("t6_rst_valid", 32'(dout_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_frame", frame_cnt, 0);
    check("t6_rst_err", err_mask, 0);
    check("t6_rst_overrun", 32'(eos_overrun), 0);
    check("t6_rst_rd_req", ch_rd_req, 0);
    exp_q.delete();
    exp_frame = '0;
    RST = 1'b0;
    tick();
    p0 = pulses[6];
    repeat (5) tick();
    check("t6_no_pops_after_rst", 32'(pulses[6]), 32'(p0));
    flush_chans();
    tick();

    // Recovery after reset
    load_chan(4, 2, 1'b1);
    tick();
    run_frame(8'h10);
    wait_idle("t7");
    check("t7_frame", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
